// File: rtl/cfg_chain_loader_if.sv
// Host/chain signal bundle for the configuration-chain loader.
// The slave modport is the loader's view; the master modport is the driving
// side (host bitstream source plus the far end of the tile chain).
interface cfg_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              cfg_data;
    logic              cfg_shift;
    logic              cfg_set;
    logic              cfg_ret;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;
    logic              busy;
    logic              done;

    modport slave (
        input  start, in_data, in_valid, cfg_ret,
        output in_ready, cfg_data, cfg_shift, cfg_set, rb_data, rb_valid, busy, done
    );

    modport master (
        output start, in_data, in_valid, cfg_ret,
        input  in_ready, cfg_data, cfg_shift, cfg_set, rb_data, rb_valid, busy, done
    );
endinterface

// File: rtl/cfg_chain_loader.sv
// Configuration-chain master: serializes bitstream words MSB-first onto the
// tile shift path, pulses cfg_set after exactly CHAIN_LEN shifts, and packs
// the bits returning from the far end of the chain into readback words.
module cfg_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    cfg_chain_loader_if.slave bus
);
    localparam int BUF_CW = $clog2(WORD_W + 1);
    localparam int RB_CW  = $clog2(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_SET,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WORD_W-1:0] r_buf;
    logic [BUF_CW-1:0] r_buf_cnt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0] r_rb_sh;
    logic [RB_CW-1:0]  r_rb_cnt;
    logic [WORD_W-1:0] r_rb_data;
    logic              r_rb_valid;

    logic              w_start_ok;
    logic              w_in_ready;
    logic              w_load;
    logic              w_shift;
    logic              w_last;
    logic              w_rb_full;
    logic              w_rb_strobe;
    logic [WORD_W-1:0] w_rb_next;
    logic              w_busy;
    logic              w_done;
    logic              w_cfg_set;

    // start only counts from a quiescent state; mid-load pulses are ignored.
    assign w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_DONE);

    // Ask for a word only when the buffer is (nearly) empty and the chain
    // still needs bits beyond what is already buffered.
    assign w_in_ready = (r_state == S_SHIFT) && (r_buf_cnt <= BUF_CW'(1)) &&
                        ((32'(r_bit_cnt) + 32'(r_buf_cnt)) < 32'(CHAIN_LEN));
    assign w_load     = w_in_ready && bus.in_valid;
    assign w_shift    = (r_state == S_SHIFT) && (r_buf_cnt != '0);
    assign w_last     = w_shift && (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));

    // Readback: the returning bit enters the LSB; a word closes after WORD_W
    // samples, or early on the final shift, left-aligned with zero padding.
    assign w_rb_next   = {r_rb_sh[WORD_W-2:0], bus.cfg_ret};
    assign w_rb_full   = (r_rb_cnt == RB_CW'(WORD_W - 1));
    assign w_rb_strobe = w_shift && (w_rb_full || w_last);

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_nxt = S_SET;
            S_SET:                  w_state_nxt = S_DONE;
            S_DONE:  if (bus.start) w_state_nxt = S_SHIFT;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state-decoded outputs.
    always_comb begin
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_cfg_set = 1'b0;
        unique case (r_state)
            S_SHIFT: w_busy = 1'b1;
            S_SET: begin
                w_busy    = 1'b1;
                w_cfg_set = 1'b1;
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Shift buffer, bit counter and readback packing.
    // NOTE: the word buffers are reset as well as the counters, because
    // cfg_data and rb_data are driven straight from them and must read 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf      <= '0;
            r_buf_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_rb_sh    <= '0;
            r_rb_cnt   <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (w_start_ok) begin
                r_buf     <= '0;
                r_buf_cnt <= '0;
                r_bit_cnt <= '0;
                r_rb_sh   <= '0;
                r_rb_cnt  <= '0;
            end else if (r_state == S_SHIFT) begin
                if (w_shift) begin
                    r_buf     <= r_buf << 1;
                    r_buf_cnt <= r_buf_cnt - BUF_CW'(1);
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    r_rb_sh   <= w_rb_next;
                    r_rb_cnt  <= w_rb_full ? '0 : r_rb_cnt + RB_CW'(1);
                end
                // A new word overrides the shift of the last buffered bit.
                if (w_load) begin
                    r_buf     <= bus.in_data;
                    r_buf_cnt <= BUF_CW'(WORD_W);
                end
                // Chain full: drop the unused low bits of the final word.
                if (w_last) begin
                    r_buf     <= '0;
                    r_buf_cnt <= '0;
                end
                if (w_rb_strobe) begin
                    r_rb_data  <= w_rb_next << (RB_CW'(WORD_W - 1) - r_rb_cnt);
                    r_rb_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.cfg_data  = r_buf[WORD_W-1];
    assign bus.cfg_shift = w_shift;
    assign bus.cfg_set   = w_cfg_set;
    assign bus.rb_data   = r_rb_data;
    assign bus.rb_valid  = r_rb_valid;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: a 16-bit chain (dut_a) and a 20-bit
// chain (dut_b), both with 8-bit words, checked against hand-computed streams.
module tb_cfg_chain_loader;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [7:0] in_data;
    logic in_valid;
    logic cfg_ret;
    logic sel;

    always #5 clk = ~clk;

    cfg_chain_loader_if #(.WORD_W(8)) if_a ();
    cfg_chain_loader_if #(.WORD_W(8)) if_b ();

    cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    assign if_a.start    = start && !sel;
    assign if_a.in_valid = in_valid && !sel;
    assign if_a.in_data  = in_data;
    assign if_a.cfg_ret  = cfg_ret;
    assign if_b.start    = start && sel;
    assign if_b.in_valid = in_valid && sel;
    assign if_b.in_data  = in_data;
    assign if_b.cfg_ret  = cfg_ret;

    wire       o_in_ready  = sel ? if_b.in_ready  : if_a.in_ready;
    wire       o_cfg_data  = sel ? if_b.cfg_data  : if_a.cfg_data;
    wire       o_cfg_shift = sel ? if_b.cfg_shift : if_a.cfg_shift;
    wire       o_cfg_set   = sel ? if_b.cfg_set   : if_a.cfg_set;
    wire [7:0] o_rb_data   = sel ? if_b.rb_data   : if_a.rb_data;
    wire       o_rb_valid  = sel ? if_b.rb_valid  : if_a.rb_valid;
    wire       o_busy      = sel ? if_b.busy      : if_a.busy;
    wire       o_done      = sel ? if_b.done      : if_a.done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] ret_pat;
    int          ret_len;
    logic        mon_clr;

    // Monitor state (written only by the monitor process).
    logic [63:0] shift_bits;
    int          n_shift, n_set, n_ready;
    int          first_shift, last_shift, set_cyc, start_cyc;
    logic [7:0]  rb_q[$];
    int          rb_cyc_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rb_at(input int i);
        if (i < rb_q.size()) return 64'(rb_q[i]);
        return 64'hDEAD_BEEF_0000_0000;
    endfunction

    function automatic logic [63:0] rbc_at(input int i);
        if (i < rb_cyc_q.size()) return 64'(rb_cyc_q[i]);
        return 64'hDEAD_BEEF_0000_0000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the selected DUT mid-cycle and model the far end of the chain.
    always @(negedge clk) begin
        if (mon_clr) begin
            shift_bits  = '0;
            n_shift     = 0;
            n_set       = 0;
            n_ready     = 0;
            first_shift = -1;
            last_shift  = -1;
            set_cyc     = -1;
            start_cyc   = -1;
            cfg_ret     = 1'b0;
            rb_q.delete();
            rb_cyc_q.delete();
        end else begin
            if (start && start_cyc < 0) start_cyc = cyc;
            if (o_in_ready) n_ready++;
            if (o_cfg_shift) begin
                if (first_shift < 0) first_shift = cyc;
                last_shift = cyc;
                shift_bits = {shift_bits[62:0], o_cfg_data};
                cfg_ret    = (n_shift < ret_len) ? ret_pat[ret_len-1-n_shift] : 1'b0;
                n_shift++;
            end
            if (o_cfg_set) begin
                n_set++;
                set_cyc = cyc;
            end
            if (o_rb_valid) begin
                rb_q.push_back(o_rb_data);
                rb_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    // Leaves control at #1 after the edge that sampled start.
    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (o_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 64'(ok), 64'd1);
    endtask

    task automatic send_word(input logic [7:0] w);
        bit ok;
        in_data  = w;
        in_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        bit ok;
        ok = 1'b0;
        dc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                dc = cyc;
                break;
            end
        end
        if (!ok) check("done_timeout", 64'(ok), 64'd1);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  64'(o_in_ready),  64'd0);
        check({tag, "_cfg_data"},  64'(o_cfg_data),  64'd0);
        check({tag, "_cfg_shift"}, 64'(o_cfg_shift), 64'd0);
        check({tag, "_cfg_set"},   64'(o_cfg_set),   64'd0);
        check({tag, "_rb_valid"},  64'(o_rb_valid),  64'd0);
        check({tag, "_rb_data"},   64'(o_rb_data),   64'd0);
        check({tag, "_busy"},      64'(o_busy),      64'd0);
        check({tag, "_done"},      64'(o_done),      64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  dc;
        bit  ok;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sel      = 1'b0;
        ret_pat  = '0;
        ret_len  = 0;
        mon_clr  = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        #1 check_all_zero("rst");
        rst = 1'b1;
        mon_clr = 1'b0;

        // 16-bit chain, A5 3C back-to-back, readback BEEF.
        ret_pat = 32'hBEEF;
        ret_len = 16;
        clear_mon();
        pulse_start();
        check("t1_ready_after_start", 64'(o_in_ready), 64'd1);
        check("t1_busy_after_start",  64'(o_busy),     64'd1);
        send_word(8'hA5);
        send_word(8'h3C);
        wait_done(dc);
        check("t1_bits",        shift_bits[15:0],            64'hA53C);
        check("t1_nshift",      64'(n_shift),                64'd16);
        check("t1_first_shift", 64'(first_shift),            64'(start_cyc + 2));
        check("t1_span",        64'(last_shift - first_shift + 1), 64'd16);
        check("t1_nset",        64'(n_set),                  64'd1);
        check("t1_set_cyc",     64'(set_cyc),                64'(start_cyc + 18));
        check("t1_done_cyc",    64'(dc),                     64'(set_cyc + 1));
        check("t1_nready",      64'(n_ready),                64'd2);
        check("t1_rb_cnt",      64'(rb_q.size()),            64'd2);
        check("t1_rb0",         rb_at(0),                    64'hBE);
        check("t1_rb1",         rb_at(1),                    64'hEF);
        check("t1_rb0_cyc",     rbc_at(0),                   64'(first_shift + 8));
        check("t1_rb1_cyc",     rbc_at(1),                   64'(set_cyc));
        check("t1_rb_hold",     64'(o_rb_data),              64'hEF);
        check("t1_busy_end",    64'(o_busy),                 64'd0);

        // Restart from DONE, 5-cycle input gap, start pulse mid-load ignored.
        clear_mon();
        pulse_start();
        check("t2_done_fell", 64'(o_done), 64'd0);
        check("t2_busy",      64'(o_busy), 64'd1);
        send_word(8'hA5);
        wait_ready(ok);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 send_word(8'h3C);
        wait_done(dc);
        check("t2_bits",   shift_bits[15:0],                  64'hA53C);
        check("t2_nshift", 64'(n_shift),                      64'd16);
        check("t2_span",   64'(last_shift - first_shift + 1), 64'd21);
        check("t2_nset",   64'(n_set),                        64'd1);
        check("t2_set",    64'(set_cyc),                      64'(last_shift + 1));
        check("t2_rb0",    rb_at(0),                          64'hBE);
        check("t2_rb1",    rb_at(1),                          64'hEF);

        // Reset after 7 shifts, then a clean reload.
        ret_len = 0;
        clear_mon();
        pulse_start();
        send_word(8'hA5);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            #1;
            if (n_shift == 7) break;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_all_zero("t3_rst");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t3_nset",   64'(n_set),   64'd0);
        check("t3_nshift", 64'(n_shift), 64'd7);
        check("t3_idle",   64'(o_busy),  64'd0);
        clear_mon();
        pulse_start();
        send_word(8'hA5);
        send_word(8'h3C);
        wait_done(dc);
        check("t3_bits",   shift_bits[15:0], 64'hA53C);
        check("t3_nshift2", 64'(n_shift),    64'd16);
        check("t3_nset2",  64'(n_set),       64'd1);

        // 20-bit chain: FF 00 F0, low nibble of the last word dropped.
        sel     = 1'b1;
        ret_pat = 32'hFFFFF;
        ret_len = 20;
        clear_mon();
        pulse_start();
        check("t4_ready_after_start", 64'(o_in_ready), 64'd1);
        send_word(8'hFF);
        send_word(8'h00);
        send_word(8'hF0);
        wait_done(dc);
        check("t4_bits",     shift_bits[19:0],                  64'hFF00F);
        check("t4_nshift",   64'(n_shift),                      64'd20);
        check("t4_span",     64'(last_shift - first_shift + 1), 64'd20);
        check("t4_nready",   64'(n_ready),                      64'd3);
        check("t4_nset",     64'(n_set),                        64'd1);
        check("t4_set_cyc",  64'(set_cyc),                      64'(start_cyc + 22));
        check("t4_done_cyc", 64'(dc),                           64'(set_cyc + 1));
        check("t4_rb_cnt",   64'(rb_q.size()),                  64'd3);
        check("t4_rb0",      rb_at(0),                          64'hFF);
        check("t4_rb1",      rb_at(1),                          64'hFF);
        check("t4_rb2",      rb_at(2),                          64'hF0);
        check("t4_rb2_cyc",  rbc_at(2),                         64'(set_cyc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Configuration-chain master for the fabric. Accepts bitstream words from a valid/ready stream, serializes them MSB-first onto the daisy-chained tile shift path, and emits a one-cycle set pulse once exactly `CHAIN_LEN` bits have been shifted. Bits returning from the far end of the chain (the previous configuration) are captured and returned as readback words. It sits between the host/bitstream interface and the first tile's shift/set inputs; the last tile's shift output returns to `cfg_ret`.

## Interface
- `WORD_W`, 32, bitstream word width; ≥2.
- `CHAIN_LEN`, 1024, total configuration bits in the chain; ≥1; need not be a multiple of `WORD_W`.
- `CNT_W`, `$clog2(CHAIN_LEN+1)`, bit-counter width.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; honoured only in IDLE or DONE.
- `in_data`  in  WORD_W  bitstream word; bit `WORD_W-1` is shifted first.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `cfg_data`  out  1  serial data to the first tile.
- `cfg_shift`  out  1  chain shift enable; the chain advances one bit on each edge where it is high.
- `cfg_set`  out  1  one-cycle apply pulse to all tiles.
- `cfg_ret`  in  1  serial data returning from the last tile.
- `rb_data`  out  WORD_W  readback word, first-returned bit in the MSB.
- `rb_valid`  out  1  one-cycle strobe; `rb_data` is valid. No backpressure.
- `busy`  out  1  high in SHIFT and SET.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE → SHIFT (`start`) → SET (`bit_cnt == CHAIN_LEN`) → DONE → SHIFT (`start`). `start` is ignored in SHIFT and SET.
- On entry to SHIFT: `bit_cnt` = 0, buffer count `buf_cnt` = 0, readback count = 0.
- `in_ready` = SHIFT && `buf_cnt` ≤ 1 && `bit_cnt + buf_cnt < CHAIN_LEN`. A handshake loads the buffer and sets `buf_cnt` = `WORD_W`. When the handshake coincides with the last buffered bit shifting out, the load takes precedence.
- `cfg_data` = buffer MSB. `cfg_shift` = SHIFT && `buf_cnt` ≠ 0. On each shift edge: buffer <<= 1, `buf_cnt`--, `bit_cnt`++.
- When `bit_cnt` reaches `CHAIN_LEN`, any remaining buffered bits (low bits of the final word) are discarded, `buf_cnt` is set to 0, and the FSM moves to SET.
- Input starvation in SHIFT drops `cfg_shift` low and holds the chain; there is no timeout.
- SET lasts exactly one cycle with `cfg_set` = 1, then moves to DONE.
- Readback: on each shift edge, `cfg_ret` is shifted into the LSB of the readback register. After every `WORD_W` samples, the register moves to `rb_data` and `rb_valid` pulses on the following cycle.
- Partial readback: if `CHAIN_LEN % WORD_W` ≠ 0, the final partial word is left-aligned, zero-padded, and strobed during the SET cycle.
- `rb_data` holds its value between strobes.

## Timing
- Reset values: state = IDLE; `in_ready`, `cfg_data`, `cfg_shift`, `cfg_set`, `rb_valid`, `busy`, `done` = 0; `rb_data` = 0; all counters = 0.
- Reset asserted mid-load returns the block to IDLE immediately. No `cfg_set` is issued, and the chain is left partially shifted.
- `start` at edge N puts the block in SHIFT from cycle N+1, with `in_ready` = 1 in that cycle.
- A word accepted at edge N: its first bit appears on `cfg_data` with `cfg_shift` = 1 in cycle N+1, and its last bit in cycle N+`WORD_W`.
- Back-to-back words stream gaplessly. Shift throughput is 1 bit per cycle, and `in_ready` is high during the last-bit cycle of each word.
- The final shift edge is followed by exactly one `cfg_set` cycle, then `done` = 1.
- Minimum load time from `start` is `CHAIN_LEN`+2 cycles, given continuous input.
- `rb_valid` pulses 1 cycle after the `WORD_W`-th sample edge.

## Test plan
- `WORD_W`=8, `CHAIN_LEN`=16; `start`, then words 0xA5, 0x3C back-to-back → `cfg_data` sequence 1010010100111100 with `cfg_shift` high for 16 consecutive cycles; `cfg_set` for one cycle immediately after; `done` = 1.
- `CHAIN_LEN`=20, `WORD_W`=8; send 0xFF, 0x00, 0xF0 → 20 shifts: 8 ones, 8 zeros, then 4 ones; low nibble of 0xF0 discarded; `in_ready` stays 0 after the third word.
- Drop `in_valid` for 5 cycles between words → `cfg_shift` is 0 for exactly those cycles, `bit_cnt` holds, and the loaded bitstream is identical to the gapless case.
- Drive `cfg_ret` with a 16-bit pattern 0xBEEF (`CHAIN_LEN`=16) → `rb_valid` strobes with `rb_data` = 0xBE, then 0xEF. With `CHAIN_LEN`=20 and return pattern 0xFFFFF, the third strobe occurs in the SET cycle with `rb_data` = 0xF0.
- Assert `rst` low after 7 shifts → all outputs 0 at once, state IDLE, no `cfg_set` ever seen. After release, a fresh `start` loads the full stream correctly.
- Pulse `start` during SHIFT → ignored, count unaffected. Pulse `start` in DONE → new load begins, `done` falls the next cycle.
